// File: rtl/rect_fill_engine.sv
// Rectangle-fill writer: clips an (x, y, w, h, colour) request to the visible frame
// and streams one pixel write per clock into video memory in raster order.
module rect_fill_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19,
    parameter int PIX_W       = 8,
    parameter int SYNC_VBLANK = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        vcount,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic [9:0]        req_w,
    input  logic [9:0]        req_h,
    input  logic [PIX_W-1:0]  req_color,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [10:0]       H_RES_11 = 11'(H_RES);
    localparam logic [10:0]       V_RES_11 = 11'(V_RES);
    localparam logic [9:0]        V_RES_10 = 10'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

    state_t r_state;
    state_t w_next;

    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [PIX_W-1:0]  r_memData;

    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [9:0]        r_w;
    logic [9:0]        r_h;
    logic [PIX_W-1:0]  r_color;

    logic [9:0]        r_col;
    logic [9:0]        r_row;
    logic [9:0]        r_xLast;
    logic [9:0]        r_yLast;
    logic [ADDR_W-1:0] r_rowBase;

    logic              w_accept;
    logic              w_perm;
    logic              w_reject;
    logic              w_lastCol;
    logic              w_lastRow;
    logic [10:0]       w_xEnd;
    logic [10:0]       w_yEnd;
    logic [10:0]       w_xEndClip;
    logic [10:0]       w_yEndClip;
    logic [9:0]        w_xLast;
    logic [9:0]        w_yLast;

    assign w_accept   = (r_state == IDLE) && r_ready && req_valid;
    assign w_perm     = (SYNC_VBLANK == 0) || (vcount >= V_RES_10);
    assign w_reject   = ({1'b0, r_x} >= H_RES_11) || ({1'b0, r_y} >= V_RES_11) ||
                        (r_w == 10'd0) || (r_h == 10'd0);

    // 11-bit sums so a rectangle running past the frame edge clips instead of wrapping
    assign w_xEnd     = {1'b0, r_x} + {1'b0, r_w};
    assign w_yEnd     = {1'b0, r_y} + {1'b0, r_h};
    assign w_xEndClip = (w_xEnd > H_RES_11) ? H_RES_11 : w_xEnd;
    assign w_yEndClip = (w_yEnd > V_RES_11) ? V_RES_11 : w_yEnd;
    assign w_xLast    = 10'(w_xEndClip - 11'd1);
    assign w_yLast    = 10'(w_yEndClip - 11'd1);

    assign w_lastCol  = (r_col == r_xLast);
    assign w_lastRow  = (r_row == r_yLast);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CLIP;
            CLIP: w_next = w_reject ? DONE : FILL;
            FILL: if (w_perm && w_lastCol && w_lastRow) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_color   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_xLast   <= '0;
            r_yLast   <= '0;
            r_rowBase <= '0;
        end else begin
            r_state <= w_next;
            // Handshake outputs trail the state so done is seen while still busy
            r_ready <= (r_state == IDLE) && (w_next == IDLE);
            r_busy  <= !((r_state == IDLE) && (w_next == IDLE));
            r_done  <= (r_state == DONE);
            r_memWe <= 1'b0;

            if (w_accept) begin
                r_x     <= req_x;
                r_y     <= req_y;
                r_w     <= req_w;
                r_h     <= req_h;
                r_color <= req_color;
            end

            if (r_state == CLIP) begin
                r_col     <= r_x;
                r_row     <= r_y;
                r_xLast   <= w_xLast;
                r_yLast   <= w_yLast;
                r_rowBase <= ADDR_W'(r_y) * H_RES_A;
            end

            // Without permission every counter holds so the fill resumes in place
            if ((r_state == FILL) && w_perm) begin
                r_memWe   <= 1'b1;
                r_memAddr <= r_rowBase + ADDR_W'(r_col);
                r_memData <= r_color;
                if (w_lastCol) begin
                    r_col     <= r_x;
                    r_row     <= r_row + 10'd1;
                    r_rowBase <= r_rowBase + H_RES_A;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_data  = r_memData;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: one free-running instance and one gated to
// vertical blanking, checked against hand-computed addresses and cycle offsets.
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  vcount = 10'd0;
    logic        valid0 = 1'b0;
    logic        valid1 = 1'b0;
    logic [9:0]  reqX = '0;
    logic [9:0]  reqY = '0;
    logic [9:0]  reqW = '0;
    logic [9:0]  reqH = '0;
    logic [7:0]  reqColor = '0;

    logic        req_ready0, mem_we0, busy0, done0;
    logic [18:0] mem_addr0;
    logic [7:0]  mem_data0;
    logic        req_ready1, mem_we1, busy1, done1;
    logic [18:0] mem_addr1;
    logic [7:0]  mem_data1;

    int cyc = 0;
    int tests = 0;
    int failed = 0;
    int acc0Cnt = 0;
    int done1Cnt = 0;
    int wrAddr0[$];
    int wrData0[$];
    int wrCyc0[$];
    int doneCyc0[$];
    int wrAddr1[$];

    rect_fill_engine #(.SYNC_VBLANK(0)) dut0 (
        .clk(clk), .rst(rst), .vcount(vcount),
        .req_valid(valid0), .req_ready(req_ready0),
        .req_x(reqX), .req_y(reqY), .req_w(reqW), .req_h(reqH), .req_color(reqColor),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .busy(busy0), .done(done0)
    );

    rect_fill_engine #(.SYNC_VBLANK(1)) dut1 (
        .clk(clk), .rst(rst), .vcount(vcount),
        .req_valid(valid1), .req_ready(req_ready1),
        .req_x(reqX), .req_y(reqY), .req_w(reqW), .req_h(reqH), .req_color(reqColor),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Edge counter plus accept counter; handshake inputs are pre-edge values here
    always @(posedge clk) begin
        cyc++;
        if (valid0 && req_ready0) acc0Cnt++;
    end

    always @(negedge clk) begin
        if (mem_we0) begin
            wrAddr0.push_back(int'(mem_addr0));
            wrData0.push_back(int'(mem_data0));
            wrCyc0.push_back(cyc);
        end
        if (done0) doneCyc0.push_back(cyc);
        if (mem_we1) wrAddr1.push_back(int'(mem_addr1));
        if (done1) done1Cnt++;
    end

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        wrAddr0.delete();
        wrData0.delete();
        wrCyc0.delete();
        doneCyc0.delete();
        wrAddr1.delete();
        acc0Cnt  = 0;
        done1Cnt = 0;
    endtask

    task automatic applyStimulus(input bit sel, input int x, input int y, input int w,
                                 input int h, input int c, output int accCyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? req_ready1 : req_ready0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("readyTimeout", 0, 1);
        reqX = 10'(x);
        reqY = 10'(y);
        reqW = 10'(w);
        reqH = 10'(h);
        reqColor = 8'(c);
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        @(posedge clk);
        #1;
        accCyc = cyc;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic waitDone0(input int bound, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done0) begin
                dc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int acc;
        int accB;
        int dc;
        int cnt;

        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_we", int'(mem_we0), 0);
        checkOutput("rst_addr", int'(mem_addr0), 0);
        checkOutput("rst_data", int'(mem_data0), 0);
        checkOutput("rst_busy", int'(busy0), 0);
        checkOutput("rst_done", int'(done0), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_readyAfter", int'(req_ready0), 1);
        #1 clearLogs();

        // Basic 2x2 fill: writes at N+2..N+5, done at N+6, ready at N+7
        applyStimulus(1'b0, 10, 5, 2, 2, 8'hE0, acc);
        waitDone0(40, dc);
        checkOutput("t1_doneCyc", dc, acc + 6);
        checkOutput("t1_readyInDone", int'(req_ready0), 0);
        checkOutput("t1_busyInDone", int'(busy0), 1);
        @(negedge clk);
        checkOutput("t1_readyBack", int'(req_ready0), 1);
        checkOutput("t1_busyLow", int'(busy0), 0);
        checkOutput("t1_donePulse", int'(done0), 0);
        checkOutput("t1_nWrites", wrAddr0.size(), 4);
        checkOutput("t1_addr0", qAt(wrAddr0, 0), 3210);
        checkOutput("t1_addr1", qAt(wrAddr0, 1), 3211);
        checkOutput("t1_addr2", qAt(wrAddr0, 2), 3850);
        checkOutput("t1_addr3", qAt(wrAddr0, 3), 3851);
        checkOutput("t1_data0", qAt(wrData0, 0), 8'hE0);
        checkOutput("t1_data3", qAt(wrData0, 3), 8'hE0);
        checkOutput("t1_firstCyc", qAt(wrCyc0, 0), acc + 2);
        checkOutput("t1_lastCyc", qAt(wrCyc0, 3), acc + 5);
        #1 clearLogs();

        // Bottom-right corner clip: only two pixels land inside the frame
        applyStimulus(1'b0, 638, 479, 5, 3, 8'h5A, acc);
        waitDone0(40, dc);
        @(negedge clk);
        checkOutput("t2_nWrites", wrAddr0.size(), 2);
        checkOutput("t2_addr0", qAt(wrAddr0, 0), 307198);
        checkOutput("t2_addr1", qAt(wrAddr0, 1), 307199);
        checkOutput("t2_data1", qAt(wrData0, 1), 8'h5A);
        checkOutput("t2_doneCyc", dc, acc + 4);
        #1 clearLogs();

        // Rejected requests: zero width, then x off the right edge
        applyStimulus(1'b0, 20, 20, 0, 4, 8'h11, acc);
        waitDone0(20, dc);
        checkOutput("t3a_doneCyc", dc, acc + 2);
        applyStimulus(1'b0, 640, 20, 3, 3, 8'h22, acc);
        waitDone0(20, dc);
        checkOutput("t3b_doneCyc", dc, acc + 2);
        @(negedge clk);
        checkOutput("t3_nWrites", wrAddr0.size(), 0);
        #1 clearLogs();

        // Vblank gating: stall before start, stall mid-fill, resume with no dup/skip
        vcount = 10'd100;
        applyStimulus(1'b1, 3, 2, 1, 4, 8'h1C, acc);
        for (int i = 0; i < 10; i++) @(negedge clk);
        checkOutput("t4_noWriteActive", wrAddr1.size(), 0);
        checkOutput("t4_busyStalled", int'(busy1), 1);
        vcount = 10'd480;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we1) cnt++;
            if (cnt == 2) break;
        end
        vcount = 10'd0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        checkOutput("t4_stallCount", wrAddr1.size(), 2);
        checkOutput("t4_stallWe", int'(mem_we1), 0);
        checkOutput("t4_addrHeld", int'(mem_addr1), 1923);
        vcount = 10'd480;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) break;
        end
        @(negedge clk);
        checkOutput("t4_nWrites", wrAddr1.size(), 4);
        checkOutput("t4_addr0", qAt(wrAddr1, 0), 1283);
        checkOutput("t4_addr1", qAt(wrAddr1, 1), 1923);
        checkOutput("t4_addr2", qAt(wrAddr1, 2), 2563);
        checkOutput("t4_addr3", qAt(wrAddr1, 3), 3203);
        checkOutput("t4_doneCount", done1Cnt, 1);
        vcount = 10'd0;
        #1 clearLogs();

        // Reset in the middle of a 10x10 fill aborts it cleanly
        applyStimulus(1'b0, 0, 10, 10, 10, 8'hFF, acc);
        for (int i = 0; i < 12; i++) @(negedge clk);
        checkOutput("t5_midFill", int'(mem_we0), 1);
        rst = 1'b0;
        #1;
        checkOutput("t5_we", int'(mem_we0), 0);
        checkOutput("t5_addr", int'(mem_addr0), 0);
        checkOutput("t5_data", int'(mem_data0), 0);
        checkOutput("t5_busy", int'(busy0), 0);
        checkOutput("t5_done", int'(done0), 0);
        checkOutput("t5_ready", int'(req_ready0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 clearLogs();
        for (int i = 0; i < 20; i++) @(negedge clk);
        checkOutput("t5_noWrites", wrAddr0.size(), 0);
        checkOutput("t5_noDone", doneCyc0.size(), 0);
        applyStimulus(1'b0, 20, 1, 3, 1, 8'h03, acc);
        waitDone0(40, dc);
        @(negedge clk);
        checkOutput("t5_newN", wrAddr0.size(), 3);
        checkOutput("t5_newAddr0", qAt(wrAddr0, 0), 660);
        checkOutput("t5_newAddr2", qAt(wrAddr0, 2), 662);
        checkOutput("t5_newData", qAt(wrData0, 1), 8'h03);
        #1 clearLogs();

        // Two back-to-back requests with valid held high: no interleaving
        applyStimulus(1'b0, 100, 50, 3, 1, 8'hA1, acc);
        valid0 = 1'b1;
        reqX = 10'd200;
        reqY = 10'd60;
        reqW = 10'd2;
        reqH = 10'd1;
        reqColor = 8'hB2;
        cnt = 0;
        @(negedge clk);
        while (!req_ready0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        accB = cyc;
        valid0 = 1'b0;
        waitDone0(40, dc);
        @(negedge clk);
        checkOutput("t6_accepts", acc0Cnt, 2);
        checkOutput("t6_dones", doneCyc0.size(), 2);
        checkOutput("t6_nWrites", wrAddr0.size(), 5);
        checkOutput("t6_a0", qAt(wrAddr0, 0), 32100);
        checkOutput("t6_a2", qAt(wrAddr0, 2), 32102);
        checkOutput("t6_b0", qAt(wrAddr0, 3), 38600);
        checkOutput("t6_b1", qAt(wrAddr0, 4), 38601);
        checkOutput("t6_bData", qAt(wrData0, 3), 8'hB2);
        checkOutput("t6_doneA", qAt(doneCyc0, 0), acc + 5);
        checkOutput("t6_bAfterDone", int'(accB > qAt(doneCyc0, 0)), 1);
        checkOutput("t6_bFirstCyc", qAt(wrCyc0, 3), accB + 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
